// File: rtl/vga_timing_pkg.sv
// Shared 640x480 raster timing constants and the coordinate type used by every
// renderer that decodes pixel_x/pixel_y.
package vga_timing_pkg;

    localparam int H_DISPLAY_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_DISPLAY_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    localparam int H_TOTAL_DEF = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int V_TOTAL_DEF = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    localparam int HS_START_DEF = H_DISPLAY_DEF + H_FRONT_DEF;
    localparam int HS_END_DEF   = HS_START_DEF + H_SYNC_DEF - 1;
    localparam int VS_START_DEF = V_DISPLAY_DEF + V_FRONT_DEF;
    localparam int VS_END_DEF   = VS_START_DEF + V_SYNC_DEF - 1;

    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    function automatic logic in_range(input int v, input int lo, input int hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Pixel-rate strobe: div_cnt runs 0..CLK_DIV-1 and p_tick marks the last count.
module tick_divider #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick
);

    // A 1-bit counter pinned at zero makes CLK_DIV=1 give a constant p_tick.
    localparam int            DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_q, div_d;

    always_comb begin
        div_d = (div_q == LAST) ? '0 : div_q + DW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) div_q <= '0;
        else       div_q <= div_d;
    end

    assign p_tick = (div_q == LAST);

endmodule

// File: rtl/vga_sync.sv
// Raster timing generator: pixel coordinates, active-low syncs, video_on, frame_tick.
// Define VGA_SYNC_PIPE_ALIGN_EN to delay hsync/vsync/video_on by one pixel period.
module vga_sync
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = H_DISPLAY_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_DISPLAY = V_DISPLAY_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       frame_tick
);

    localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_DISPLAY + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_DISPLAY + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC - 1;

    coord_t h_q, h_d, v_q, v_d;
    logic   h_last, v_last;
    logic   hs_q, hs_d, vs_q, vs_d, vo_q, vo_d;

    tick_divider #(.CLK_DIV(CLK_DIV)) u_div (
        .clk    (clk),
        .reset  (reset),
        .p_tick (p_tick)
    );

    assign h_last = (int'(h_q) == H_TOTAL - 1);
    assign v_last = (int'(v_q) == V_TOTAL - 1);

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (p_tick) begin
            if (h_last) begin
                h_d = '0;
                v_d = v_last ? '0 : v_q + coord_t'(1);
            end else begin
                h_d = h_q + coord_t'(1);
            end
        end
    end

    // Decoding the next counts keeps the syncs aligned with the coordinates they load with.
    always_comb begin
        hs_d = !in_range(int'(h_d), HS_START, HS_END);
        vs_d = !in_range(int'(v_d), VS_START, VS_END);
        vo_d = (int'(h_d) < H_DISPLAY) && (int'(v_d) < V_DISPLAY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_q  <= '0;
            v_q  <= '0;
            hs_q <= 1'b1;
            vs_q <= 1'b1;
            vo_q <= 1'b1;
        end else begin
            h_q  <= h_d;
            v_q  <= v_d;
            hs_q <= hs_d;
            vs_q <= vs_d;
            vo_q <= vo_d;
        end
    end

`ifdef VGA_SYNC_PIPE_ALIGN_EN
    logic hs_p_q, vs_p_q, vo_p_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hs_p_q <= 1'b1;
            vs_p_q <= 1'b1;
            vo_p_q <= 1'b1;
        end else if (p_tick) begin
            hs_p_q <= hs_q;
            vs_p_q <= vs_q;
            vo_p_q <= vo_q;
        end
    end

    assign hsync    = hs_p_q;
    assign vsync    = vs_p_q;
    assign video_on = vo_p_q;
`else
    assign hsync    = hs_q;
    assign vsync    = vs_q;
    assign video_on = vo_q;
`endif

    assign pixel_x    = h_q;
    assign pixel_y    = v_q;
    assign frame_tick = p_tick && h_last && v_last;

endmodule

// File: tb/tb_vga_sync.sv
// Directed bench: default 640x480 timing at CLK_DIV=4 and 1, plus a tiny raster
// (15x11, CLK_DIV=2) so whole frames, vsync and frame_tick fit in a short run.
module tb_vga_sync;

`ifdef VGA_SYNC_PIPE_ALIGN_EN
    localparam int PIPE = 1;
`else
    localparam int PIPE = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b, rst_c;
    logic       pt_a, pt_b, pt_c;
    logic [9:0] x_a, y_a, x_b, y_b, x_c, y_c;
    logic       hs_a, vs_a, vo_a, ft_a;
    logic       hs_b, vs_b, vo_b, ft_b;
    logic       hs_c, vs_c, vo_c, ft_c;

    int n_assert = 0;
    int n_fail   = 0;
    int hs_low_cnt = 0;

    vga_sync #(.CLK_DIV(4)) dut_a (
        .clk(clk), .reset(rst_a), .p_tick(pt_a), .pixel_x(x_a), .pixel_y(y_a),
        .hsync(hs_a), .vsync(vs_a), .video_on(vo_a), .frame_tick(ft_a)
    );

    vga_sync #(.CLK_DIV(1)) dut_b (
        .clk(clk), .reset(rst_b), .p_tick(pt_b), .pixel_x(x_b), .pixel_y(y_b),
        .hsync(hs_b), .vsync(vs_b), .video_on(vo_b), .frame_tick(ft_b)
    );

    vga_sync #(
        .CLK_DIV(2), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(1)
    ) dut_c (
        .clk(clk), .reset(rst_c), .p_tick(pt_c), .pixel_x(x_c), .pixel_y(y_c),
        .hsync(hs_c), .vsync(vs_c), .video_on(vo_c), .frame_tick(ft_c)
    );

    task automatic chk(input string tag, input int n, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s n=%0d observed=%0h expected=%0h", tag, n, obs, exp);
        end
    endtask

    // {hsync, vsync, video_on} for a pixel, given sync windows and visible size
    function automatic logic [2:0] sync_exp(input int x, input int y, input int hlo, input int hhi,
                                            input int vlo, input int vhi, input int hd, input int vd);
        logic hs, vs, vo;
        hs = !((x >= hlo) && (x <= hhi));
        vs = !((y >= vlo) && (y <= vhi));
        vo = (x < hd) && (y < vd);
        return {hs, vs, vo};
    endfunction

    function automatic logic [2:0] exp_a(input int n);
        int nd;
        nd = n - PIPE * 4;
        if (nd < 0) return 3'b111;
        return sync_exp((nd / 4) % 800, (nd / 3200) % 525, 656, 751, 490, 491, 640, 480);
    endfunction

    function automatic logic [2:0] exp_c(input int n);
        int nd;
        nd = n - PIPE * 2;
        if (nd < 0) return 3'b111;
        return sync_exp((nd / 2) % 15, (nd / 30) % 11, 10, 12, 8, 9, 8, 6);
    endfunction

    initial begin
        logic [2:0] e;
        rst_a = 1'b1;
        rst_b = 1'b1;
        rst_c = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("b_ptick_in_reset", 0, pt_b, 1);
        rst_a = 1'b0;
        rst_b = 1'b0;
        rst_c = 1'b0;

        chk("a_rst_x", 0, x_a, 0);
        chk("a_rst_y", 0, y_a, 0);
        chk("a_rst_sync", 0, {hs_a, vs_a, vo_a}, 3'b111);
        chk("a_rst_ptick", 0, pt_a, 0);
        chk("a_rst_ftick", 0, ft_a, 0);
        chk("b_rst_x", 0, x_b, 0);
        chk("c_rst_sync", 0, {hs_c, vs_c, vo_c}, 3'b111);

        for (int n = 1; n <= 6001; n++) begin
            @(posedge clk);
            #1;

            if (n <= 3300) begin
                chk("a_ptick", n, pt_a, (n % 4 == 3) ? 1 : 0);
                chk("a_x", n, x_a, (n / 4) % 800);
                chk("a_y", n, y_a, (n / 3200) % 525);
                e = exp_a(n);
                chk("a_hsync", n, hs_a, e[2]);
                chk("a_vsync", n, vs_a, e[1]);
                chk("a_video_on", n, vo_a, e[0]);
                chk("a_ftick", n, ft_a, 0);
                if (n <= 3200 && hs_a == 1'b0) hs_low_cnt++;
            end
            if (n == 3300) chk("a_hs_low_clks", n, hs_low_cnt, 384);

            if (n == 6000) begin
                e = exp_a(n);
                chk("a_pre_rst_x", n, x_a, 700);
                chk("a_pre_rst_hsync", n, hs_a, e[2]);
                chk("a_pre_rst_hs_low", n, hs_a, 0);
                rst_a = 1'b1;
            end
            if (n == 6001) begin
                chk("a_midrst_x", n, x_a, 0);
                chk("a_midrst_y", n, y_a, 0);
                chk("a_midrst_sync", n, {hs_a, vs_a, vo_a}, 3'b111);
                chk("a_midrst_ptick", n, pt_a, 0);
                rst_a = 1'b0;
            end

            if (n <= 805) begin
                chk("b_ptick", n, pt_b, 1);
                chk("b_x", n, x_b, n % 800);
                chk("b_y", n, y_b, (n / 800) % 525);
                chk("b_ftick", n, ft_b, 0);
            end

            if (n <= 700) begin
                chk("c_ptick", n, pt_c, (n % 2 == 1) ? 1 : 0);
                chk("c_x", n, x_c, (n / 2) % 15);
                chk("c_y", n, y_c, (n / 30) % 11);
                e = exp_c(n);
                chk("c_hsync", n, hs_c, e[2]);
                chk("c_vsync", n, vs_c, e[1]);
                chk("c_video_on", n, vo_c, e[0]);
                chk("c_ftick", n, ft_c, (n % 330 == 329) ? 1 : 0);
            end

            if (n == 952) begin
                chk("c_pre_rst_x", n, x_c, 11);
                chk("c_pre_rst_y", n, y_c, 9);
                chk("c_pre_rst_hs_vs", n, {hs_c, vs_c}, 2'b00);
                rst_c = 1'b1;
            end
            if (n == 953) begin
                chk("c_midrst_x", n, x_c, 0);
                chk("c_midrst_y", n, y_c, 0);
                chk("c_midrst_sync", n, {hs_c, vs_c, vo_c}, 3'b111);
                chk("c_midrst_ftick", n, ft_c, 0);
                rst_c = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
